// File: rtl/delayslot_redirect_pkg.sv
// delayslot_redirect_pkg: shared types for the fetch-redirect controller.
`default_nettype none

package delayslot_redirect_pkg;

  localparam int DR_VIRT_W = 32;

  typedef logic [DR_VIRT_W-1:0] virt_t;

  typedef enum logic [1:0] {
    DR_IDLE    = 2'd0,
    DR_WAIT_DS = 2'd1,
    DR_REQ     = 2'd2
  } ds_redirect_state_t;

endpackage

`default_nettype wire

// File: rtl/delayslot_redirect_if.sv
// delayslot_redirect_if: execute resolution, decode delay-slot flags and fetch redirect bundle.
`default_nettype none

interface delayslot_redirect_if #(
  parameter int N_ISSUE = 1,
  parameter int ADDR_W  = 32
);
  logic              br_valid;
  logic              br_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              br_ds_in_pipe;
  logic [N_ISSUE-1:0] ds_decoded;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [ADDR_W-1:0] redirect_pc;
  logic              kill_frontend;

  // Pipeline side: drives resolutions, delay-slot flags and fetch readiness.
  modport master (
    output br_valid, br_taken, br_target, br_ds_in_pipe, ds_decoded, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc, kill_frontend
  );

  modport slave (
    input  br_valid, br_taken, br_target, br_ds_in_pipe, ds_decoded, redirect_ready,
    output br_ready, redirect_valid, redirect_pc, kill_frontend
  );
endinterface

`default_nettype wire

// File: rtl/delayslot_redirect_sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones; cleared only by reset.
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/delayslot_redirect.sv
// delayslot_redirect: holds a taken redirect until its delay slot reaches decode,
// then hands it to fetch with a valid/ready handshake and a front-end kill pulse.
`default_nettype none

module delayslot_redirect
  import delayslot_redirect_pkg::*;
#(
  parameter int N_ISSUE = 1,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  delayslot_redirect_if.slave  bus,
  output logic [CNT_W-1:0]     perf_redirects,
  output logic [CNT_W-1:0]     perf_ds_wait
);

  ds_redirect_state_t state, state_nxt;
  logic [ADDR_W-1:0]  pc_q;
  logic [N_ISSUE-1:0] ds_vec;
  logic               ds_any;
  logic               br_ready_w;
  logic               accept_taken;
  logic               req_active;
  logic               fetch_accept;

  assign ds_vec       = bus.ds_decoded;
  assign ds_any       = |ds_vec;
  assign br_ready_w   = (state == DR_IDLE) & ~flush;
  assign accept_taken = bus.br_valid & br_ready_w & bus.br_taken;
  assign req_active   = (state == DR_REQ);
  // A flush owns the front end, so it suppresses both the kill and the count.
  assign fetch_accept = req_active & bus.redirect_ready & ~flush;

  assign bus.br_ready       = br_ready_w;
  assign bus.redirect_valid = req_active;
  assign bus.redirect_pc    = pc_q;
  assign bus.kill_frontend  = fetch_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DR_IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept_taken) begin
        pc_q <= bus.br_target;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = DR_IDLE;
    end else begin
      case (state)
        DR_IDLE: begin
          if (accept_taken) begin
            state_nxt = (bus.br_ds_in_pipe | ds_any) ? DR_REQ : DR_WAIT_DS;
          end
        end
        DR_WAIT_DS: begin
          if (ds_any) begin
            state_nxt = DR_REQ;
          end
        end
        DR_REQ: begin
          if (bus.redirect_ready) begin
            state_nxt = DR_IDLE;
          end
        end
        default: state_nxt = DR_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ctr_redirects (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fetch_accept),
    .count (perf_redirects)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ctr_ds_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == DR_WAIT_DS),
    .count (perf_ds_wait)
  );

endmodule

`default_nettype wire

// File: doc/delayslot_redirect.md
# delayslot_redirect

Fetch-redirect controller: the consumer of the decode stage's `resolved_delayslot` flags. It takes a taken control-flow resolution from execute and holds the redirect until that instruction's delay slot has entered decode. It then presents the redirect to fetch with a valid/ready handshake and pulses a front-end kill of everything younger than the delay slot. It sits between execute (branch resolution), decode (delay-slot flags) and fetch (PC mux).

## Interface
- `N_ISSUE`, default 1: decode issue width; the width of `ds_decoded`.
- `ADDR_W`, default 32: PC width.
- `CNT_W`, default 32: width of each performance counter.

Ports (clock and reset first):
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: exception/eret flush, same signal as the decode-stage flush.
- `br_valid` in 1: execute presents a resolved control-flow instruction.
- `br_ready` out 1: block can accept a resolution.
- `br_taken` in 1: resolution is taken.
- `br_target` in `ADDR_W`: redirect target.
- `br_ds_in_pipe` in 1: the delay slot is already at or past decode.
- `ds_decoded` in `N_ISSUE`: `resolved_delayslot` from decode; any set bit means the delay slot entered decode this cycle.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_pc` out `ADDR_W`: held target.
- `kill_frontend` out 1: one-cycle kill of IF/ID contents younger than the delay slot.
- `perf_redirects` out `CNT_W`: count of accepted redirects.
- `perf_ds_wait` out `CNT_W`: count of cycles spent in WAIT_DS.

## Operation
- Accept handshake: a resolution is accepted when `br_valid & br_ready`. `br_ready = (state == IDLE) & ~flush`.
- FSM states are IDLE, WAIT_DS and REQ.
- IDLE, accept with `br_taken=0`: no action; stay in IDLE.
- IDLE, accept with `br_taken=1`:
  - `br_target` is latched into `redirect_pc`.
  - If `br_ds_in_pipe | (|ds_decoded)`, go to REQ.
  - Otherwise go to WAIT_DS.
- WAIT_DS:
  - `perf_ds_wait` increments every cycle spent in this state.
  - If `|ds_decoded`, go to REQ. Otherwise remain in WAIT_DS.
- REQ:
  - `redirect_valid=1`.
  - `redirect_pc` is stable until acceptance.
  - When `redirect_ready`:
    - `kill_frontend` pulses that same cycle (`kill_frontend = redirect_valid & redirect_ready`).
    - `perf_redirects` increments.
    - Go to IDLE.
- `flush` has highest priority. In any state, the next state is IDLE, any pending redirect is dropped, and no `kill_frontend` is issued that cycle (the flush owns the front end). A `br_valid` arriving in the same cycle as `flush` is not accepted.
- `ds_decoded` pulses while in IDLE or REQ are ignored.
- A control-flow instruction in a delay slot is architecturally undefined. It is blocked by `br_ready=0` and is never reordered.
- Counters saturate at all-ones. They are cleared only by reset; `flush` does not clear them.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - State is IDLE.
  - `redirect_valid=0`.
  - `redirect_pc=0`.
  - `kill_frontend=0`.
  - Both counters are 0.
  - `br_ready` is 1 once `rst_n` deasserts.
- Reset mid-REQ drops the request immediately, without waiting for a clock edge.
- Latency, delay slot already present: taken accept in cycle t gives `redirect_valid` in cycle t+1.
- Latency, waiting for the delay slot: first `ds_decoded` bit in cycle t gives `redirect_valid` in cycle t+1.
- REQ with `redirect_ready=0` holds indefinitely. `redirect_valid` and `redirect_pc` must not change until acceptance or flush.
- Back-to-back: after acceptance in cycle t, `br_ready=1` in cycle t+1. The next redirect can therefore appear no earlier than t+2.

## Structure
- The `inst_decode.svh` package gains two definitions:
  - `typedef enum logic [1:0] {DR_IDLE, DR_WAIT_DS, DR_REQ} ds_redirect_state_t`.
  - `typedef logic [ADDR_W-1:0] virt_t`, for the PC type, if it is not already present.
- Sub-module: `sat_counter #(CNT_W)`, with an enable and a saturating increment, instantiated twice.
- The FSM, the target register and the handshake logic live in this module.

## Test plan
- Taken branch with the delay slot already present: reset, then `br_valid=1, br_taken=1, br_target=0xBFC00100, br_ds_in_pipe=1` with `redirect_ready=1`. Expect:
  - cycle+1: `redirect_valid=1`, `redirect_pc=0xBFC00100`, `kill_frontend=1`.
  - cycle+2: `br_ready=1`, `perf_redirects=1`.
- Waiting for the delay slot: taken with `br_ds_in_pipe=0`, then `ds_decoded=0` for 3 cycles, then `ds_decoded=1`. Expect `redirect_valid` the cycle after the pulse and `perf_ds_wait=4`.
- Not-taken branch: `br_taken=0`. Expect no `redirect_valid`, state stays IDLE, counters unchanged.
- Fetch backpressure: in REQ, hold `redirect_ready=0` for 5 cycles while driving `br_valid=1`. Expect:
  - `redirect_pc` stable.
  - `br_ready=0` throughout.
  - Exactly one `kill_frontend` once ready rises.
- Flush preemption:
  - `flush` in WAIT_DS returns to IDLE with no redirect, even if `ds_decoded` fires the same cycle.
  - `flush` during REQ with `redirect_ready=1` gives `kill_frontend=0` and `perf_redirects` unchanged.
- Async reset and saturation:
  - Assert `rst_n=0` mid-clock in REQ. Expect `redirect_valid` to drop before the next edge.
  - With `CNT_W=4`, run 20 redirects. Expect `perf_redirects=15`.
